// File: rtl/routing_pkg.sv
// routing_pkg: shared select-per-wire constant, loader FSM states and word-count helper
package routing_pkg;
  localparam int SEL_PER_WIRE = 12;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} cfg_state_e;
  function automatic int cfg_words(input int total, input int word);
    return (total + word - 1) / word;
  endfunction
endpackage

// File: rtl/bidir_routing_block.sv
// bidir_routing_block: per-wire tristate switch box; sel[w*12+k] drives side dst from side src (k = L>R,L>T,L>B,R>L,R>T,R>B,T>L,T>R,T>B,B>L,B>R,B>T)
module bidir_routing_block
  import routing_pkg::*;
#(
  parameter int WIRE_WIDTH = 3
) (
  input logic [WIRE_WIDTH*SEL_PER_WIRE-1:0] sel,
  inout wire  [WIRE_WIDTH-1:0]              left,
  inout wire  [WIRE_WIDTH-1:0]              right,
  inout wire  [WIRE_WIDTH-1:0]              top,
  inout wire  [WIRE_WIDTH-1:0]              bottom
);
  for (genvar w = 0; w < WIRE_WIDTH; w++) begin : g_wire
    logic [SEL_PER_WIRE-1:0] s;
    assign s = sel[w*SEL_PER_WIRE +: SEL_PER_WIRE];
    assign right[w]  = s[0]  ? left[w]   : 1'bz;
    assign top[w]    = s[1]  ? left[w]   : 1'bz;
    assign bottom[w] = s[2]  ? left[w]   : 1'bz;
    assign left[w]   = s[3]  ? right[w]  : 1'bz;
    assign top[w]    = s[4]  ? right[w]  : 1'bz;
    assign bottom[w] = s[5]  ? right[w]  : 1'bz;
    assign left[w]   = s[6]  ? top[w]    : 1'bz;
    assign right[w]  = s[7]  ? top[w]    : 1'bz;
    assign bottom[w] = s[8]  ? top[w]    : 1'bz;
    assign left[w]   = s[9]  ? bottom[w] : 1'bz;
    assign right[w]  = s[10] ? bottom[w] : 1'bz;
    assign top[w]    = s[11] ? bottom[w] : 1'bz;
  end
endmodule

// File: rtl/cfg_shift_loader.sv
// cfg_shift_loader: IDLE/LOAD/FULL word-serial loader; cfg_start/valid/data/commit in, cfg_ready/full/shadow out
module cfg_shift_loader
  import routing_pkg::*;
#(
  parameter  int CFG_WORD = 8,
  parameter  int TOTAL    = 180,
  localparam int N_WORDS  = cfg_words(TOTAL, CFG_WORD),
  localparam int SW       = N_WORDS * CFG_WORD,
  localparam int CW       = $clog2(N_WORDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [CFG_WORD-1:0] cfg_data,
  input  logic                cfg_commit,
  output logic                cfg_ready,
  output logic                full,
  output logic [TOTAL-1:0]    shadow
);
  cfg_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sr;
  logic accept;
  assign cfg_ready = state == LOAD;
  assign full = state == FULL;
  assign accept = cfg_ready & cfg_valid & ~cfg_start;
  assign shadow = sr[TOTAL-1:0];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (cfg_start) begin
      state_n = LOAD;
      cnt_n = '0;
    end else if (accept) begin
      cnt_n = cnt + 1'b1;
      state_n = cnt == CW'(N_WORDS - 1) ? FULL : LOAD;
    end else if (full & cfg_commit) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) sr <= SW'({cfg_data, sr} >> CFG_WORD);
    end
endmodule

// File: rtl/routing_row_cfg.sv
// routing_row_cfg: row of routing tiles left->right; cfg_* loads/commits selects, sel_active readback, left/right/top/bottom channels
module routing_row_cfg
  import routing_pkg::*;
#(
  parameter  int WIRE_WIDTH = 3,
  parameter  int FPGA_WIDTH = 5,
  parameter  int CFG_WORD   = 8,
  localparam int SEL_W      = WIRE_WIDTH * SEL_PER_WIRE,
  localparam int TOTAL      = FPGA_WIDTH * SEL_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [CFG_WORD-1:0]              cfg_data,
  input  logic                             cfg_commit,
  input  logic                             cfg_clear,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic [TOTAL-1:0]                 sel_active,
  inout  wire  [WIRE_WIDTH-1:0]            left,
  inout  wire  [WIRE_WIDTH-1:0]            right,
  inout  wire  [WIRE_WIDTH*FPGA_WIDTH-1:0] top,
  inout  wire  [WIRE_WIDTH*FPGA_WIDTH-1:0] bottom
);
  logic [TOTAL-1:0] shadow;
  logic full, commit_ok;
  cfg_shift_loader #(.CFG_WORD(CFG_WORD), .TOTAL(TOTAL)) u_loader (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_ready(cfg_ready),
    .full(full), .shadow(shadow)
  );
  assign commit_ok = full & cfg_commit & ~cfg_clear;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_active <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      sel_active <= cfg_clear ? '0 : commit_ok ? shadow : sel_active;
      cfg_done <= commit_ok;
      cfg_err <= cfg_commit & ~full;
    end
  if (FPGA_WIDTH == 1) begin : g_single
    bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_tile (
      .sel(sel_active), .left(left), .right(right), .top(top), .bottom(bottom)
    );
  end else begin : g_row
    wire [(FPGA_WIDTH-1)*WIRE_WIDTH-1:0] link;
    for (genvar x = 0; x < FPGA_WIDTH; x++) begin : g_tile
      if (x == 0) begin : g_first
        bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_tile (
          .sel(sel_active[0 +: SEL_W]), .left(left), .right(link[0 +: WIRE_WIDTH]),
          .top(top[0 +: WIRE_WIDTH]), .bottom(bottom[0 +: WIRE_WIDTH])
        );
      end else if (x == FPGA_WIDTH - 1) begin : g_last
        bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_tile (
          .sel(sel_active[x*SEL_W +: SEL_W]), .left(link[(x-1)*WIRE_WIDTH +: WIRE_WIDTH]),
          .right(right), .top(top[x*WIRE_WIDTH +: WIRE_WIDTH]),
          .bottom(bottom[x*WIRE_WIDTH +: WIRE_WIDTH])
        );
      end else begin : g_mid
        bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_tile (
          .sel(sel_active[x*SEL_W +: SEL_W]), .left(link[(x-1)*WIRE_WIDTH +: WIRE_WIDTH]),
          .right(link[x*WIRE_WIDTH +: WIRE_WIDTH]), .top(top[x*WIRE_WIDTH +: WIRE_WIDTH]),
          .bottom(bottom[x*WIRE_WIDTH +: WIRE_WIDTH])
        );
      end
    end
  end
endmodule
